// File: rtl/chi_step_engine.sv
// Iterative Keccak-f chi step over a 5x5 lane state.
// Transforms PLANES_PER_CYC planes per RUN cycle, with valid/ready handshakes on input and output.
module chi_step_engine #(
   parameter int unsigned LANE_W         = 64,
   parameter int unsigned PLANES_PER_CYC = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [25*LANE_W-1:0] in_state,
   input  logic                 in_chi_en,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [25*LANE_W-1:0] out_state,
   output logic                 busy
);

   localparam int unsigned STATE_W = 25 * LANE_W;
   localparam logic [2:0]  PC_STEP = 3'(PLANES_PER_CYC);

   if (PLANES_PER_CYC != 1 && PLANES_PER_CYC != 5) begin : g_bad_ppc
      $error("chi_step_engine: PLANES_PER_CYC must be 1 or 5");
   end
   if (LANE_W != 1 && LANE_W != 2 && LANE_W != 4 && LANE_W != 8 &&
       LANE_W != 16 && LANE_W != 32 && LANE_W != 64) begin : g_bad_lane_w
      $error("chi_step_engine: LANE_W must be a power of two from 1 to 64");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

   fsm_t               fsm_q, fsm_d;
   logic [2:0]         pc_q;
   logic               chi_en_q;
   logic [STATE_W-1:0] st_q;
   logic [STATE_W-1:0] st_run;
   logic               last_step;

   assign last_step = (pc_q + PC_STEP) == 3'd5;

   // Planes outside the current pc window pass through untouched.
   always_comb begin
      st_run = st_q;
      for (int unsigned y = 0; y < 5; y++) begin
         if (chi_en_q && y >= 32'(pc_q) && y < 32'(pc_q) + PLANES_PER_CYC) begin
            for (int unsigned x = 0; x < 5; x++) begin
               st_run[(x + 5*y)*LANE_W +: LANE_W] =
                  st_q[(x + 5*y)*LANE_W +: LANE_W] ^
                  (~st_q[((x + 1) % 5 + 5*y)*LANE_W +: LANE_W] &
                    st_q[((x + 2) % 5 + 5*y)*LANE_W +: LANE_W]);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q <= IDLE;
      end else begin
         fsm_q <= fsm_d;
      end
   end

   always_comb begin
      fsm_d = fsm_q;
      case (fsm_q)
         IDLE:    if (in_valid)  fsm_d = RUN;
         RUN:     if (last_step) fsm_d = DONE;
         DONE:    if (out_ready) fsm_d = IDLE;
         default: fsm_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (fsm_q == IDLE);
      out_valid = (fsm_q == DONE);
      busy      = (fsm_q != IDLE);
   end

   // pc is cleared when leaving RUN so it is already 0 on re-entry to IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q     <= '0;
         chi_en_q <= 1'b0;
         st_q     <= '0;
      end else begin
         case (fsm_q)
            IDLE: begin
               if (in_valid) begin
                  st_q     <= in_state;
                  chi_en_q <= in_chi_en;
                  pc_q     <= '0;
               end
            end
            RUN: begin
               st_q <= st_run;
               pc_q <= last_step ? 3'd0 : pc_q + PC_STEP;
            end
            default: ;
         endcase
      end
   end

   assign out_state = st_q;

endmodule
